pattern_sequencer: RTL and testbench



---
 rtl/pattern_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pattern_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: time-shares the panel row path between NUM_PATTERNS sources,
// with blanking gaps and a lap-stepped colour. Define PATTERN_SEQ_AUTO_ADVANCE_EN for dwell-timer advance.
package pattern_sequencer_pkg;
  localparam int GL_RGB_ROW_W = 48;
  typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;
endpackage

module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_TIMER  = 50_000_000,
  parameter int BLANK_CYCLES = 16,
  localparam int SEL_W       = $clog2(NUM_PATTERNS)
) (
  input  logic                               clk_in,
  input  logic                               n_reset_in,
  input  logic                               next_in,
  input  logic                               hold_in,
  input  logic [NUM_PATTERNS*GL_RGB_ROW_W-1:0] row_in,
  input  logic [NUM_PATTERNS*4-1:0]          row_address_in,
  output rgb_row_t                           row_out,
  output logic [3:0]                         row_address_out,
  output logic [2:0]                         colour_out,
  output logic [SEL_W-1:0]                   pattern_sel_out,
  output logic [NUM_PATTERNS-1:0]            pattern_n_reset_out,
  output logic                               busy_out
);

  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  if (NUM_PATTERNS < 2 || BLANK_CYCLES < 1 || DWELL_TIMER < 1) begin : g_bad_params
    $error("pattern_sequencer: invalid parameters");
  end

  typedef enum logic [1:0] {S_START, S_RUN, S_BLANK} state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [2:0]              colour_q, colour_d;
  rgb_row_t                row_q, row_d;
  logic [3:0]              row_addr_q, row_addr_d;
  logic [3:0]              addr_cnt_q, addr_cnt_d;
  logic [NUM_PATTERNS-1:0] src_nrst_q, src_nrst_d;
  logic                    busy_q, busy_d;
  logic [BLANK_W-1:0]      blank_cnt_q, blank_cnt_d;
  logic                    dwell_expire_s;
  logic                    advance_s;

  assign advance_s = (state_q == S_RUN) && !hold_in && (next_in || dwell_expire_s);

`ifdef PATTERN_SEQ_AUTO_ADVANCE_EN
  localparam int DWELL_W = $clog2(DWELL_TIMER + 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign dwell_expire_s = (state_q == S_RUN) && (dwell_q == DWELL_W'(DWELL_TIMER - 1));

  // Dwell timer runs only in S_RUN while not held; any advance restarts it.
  always_comb begin
    dwell_d = dwell_q;
    if (state_q == S_RUN && !hold_in) begin
      if (advance_s) begin
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  assign dwell_expire_s = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    colour_d    = colour_q;
    blank_cnt_d = blank_cnt_q;
    addr_cnt_d  = addr_cnt_q + 4'd1;
    case (state_q)
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (advance_s) begin
          state_d     = S_BLANK;
          blank_cnt_d = BLANK_W'(BLANK_CYCLES - 1);
          if (sel_q == SEL_W'(NUM_PATTERNS - 1)) begin
            sel_d    = '0;
            colour_d = (colour_q == 3'd7) ? 3'd1 : colour_q + 3'd1;
          end else begin
            sel_d    = sel_q + SEL_W'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_BLANK: begin
        if (blank_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end
      end
      default: state_d = S_START;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as it.
  always_comb begin
    src_nrst_d = '0;
    if (state_d == S_RUN) begin
      row_d             = row_in[int'(sel_d)*GL_RGB_ROW_W +: GL_RGB_ROW_W];
      row_addr_d        = row_address_in[int'(sel_d)*4 +: 4];
      src_nrst_d[sel_d] = 1'b1;
      busy_d            = 1'b0;
    end else begin
      row_d             = '0;
      row_addr_d        = addr_cnt_q;
      busy_d            = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q     <= S_START;
      sel_q       <= '0;
      colour_q    <= 3'b001;
      row_q       <= '0;
      row_addr_q  <= 4'd0;
      addr_cnt_q  <= 4'd0;
      src_nrst_q  <= '0;
      busy_q      <= 1'b1;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      colour_q    <= colour_d;
      row_q       <= row_d;
      row_addr_q  <= row_addr_d;
      addr_cnt_q  <= addr_cnt_d;
      src_nrst_q  <= src_nrst_d;
      busy_q      <= busy_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign row_out             = row_q;
  assign row_address_out     = row_addr_q;
  assign colour_out          = colour_q;
  assign pattern_sel_out     = sel_q;
  assign pattern_n_reset_out = src_nrst_q;
  assign busy_out            = busy_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer against a lap/advance-count reference model.
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  localparam int NP    = 4;
  localparam int DWELL = 100;
  localparam int BLANK = 16;
  localparam int W     = GL_RGB_ROW_W;
`ifdef PATTERN_SEQ_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                clk_in = 1'b0;
  logic                n_reset_in;
  logic                next_in;
  logic                hold_in;
  logic [NP*W-1:0]     row_in;
  logic [NP*4-1:0]     row_address_in;
  rgb_row_t            row_out;
  logic [3:0]          row_address_out;
  logic [2:0]          colour_out;
  logic [1:0]          pattern_sel_out;
  logic [NP-1:0]       pattern_n_reset_out;
  logic                busy_out;

  int checks = 0;
  int errors = 0;

  pattern_sequencer #(.NUM_PATTERNS(NP), .DWELL_TIMER(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk_in              (clk_in),
    .n_reset_in          (n_reset_in),
    .next_in             (next_in),
    .hold_in             (hold_in),
    .row_in              (row_in),
    .row_address_in      (row_address_in),
    .row_out             (row_out),
    .row_address_out     (row_address_out),
    .colour_out          (colour_out),
    .pattern_sel_out     (pattern_sel_out),
    .pattern_n_reset_out (pattern_n_reset_out),
    .busy_out            (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: mode 0 = start, 1 = running, 2 = blanking
  int        m_mode;
  int        m_edges;
  int        m_advances;
  int        m_blank_end;
  int        m_dwell;
  int        hold_left;
  logic [W-1:0]  e_row;
  logic [3:0]    e_addr;
  logic [2:0]    e_colour;
  logic [1:0]    e_sel;
  logic [NP-1:0] e_nrst;
  logic          e_busy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_row"},    64'(row_out),             64'd0);
    check_eq({tag, "_addr"},   64'(row_address_out),     64'd0);
    check_eq({tag, "_colour"}, 64'(colour_out),          64'd1);
    check_eq({tag, "_sel"},    64'(pattern_sel_out),     64'd0);
    check_eq({tag, "_nrst"},   64'(pattern_n_reset_out), 64'd0);
    check_eq({tag, "_busy"},   64'(busy_out),            64'd1);
  endtask

  task automatic model_reset();
    m_mode = 0; m_edges = 0; m_advances = 0; m_blank_end = 0; m_dwell = 0;
  endtask

  task automatic drive_random();
    logic [63:0] r64;
    for (int s = 0; s < NP; s++) begin
      r64 = {$urandom(), $urandom()};
      row_in[s*W +: W] = r64[W-1:0];
      row_address_in[s*4 +: 4] = 4'($urandom_range(0, 15));
    end
    if (hold_left > 0) begin
      hold_in = 1'b1;
      hold_left--;
    end else if ($urandom_range(0, 39) == 0) begin
      hold_in = 1'b1;
      hold_left = $urandom_range(5, 25);
    end else begin
      hold_in = 1'b0;
    end
    next_in = ($urandom_range(0, 5) == 0);
  endtask

  // Predict outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    int sel;
    bit adv;
    m_edges++;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      adv = !hold_in && (next_in || (AUTO && m_dwell == DWELL - 1));
      if (adv) begin
        m_advances++;
        m_blank_end = m_edges + BLANK;
        m_mode = 2;
        m_dwell = 0;
      end else if (!hold_in) begin
        m_dwell++;
      end
    end else if (m_edges == m_blank_end) begin
      m_mode = 1;
    end
    sel      = m_advances % NP;
    e_sel    = 2'(sel);
    e_colour = 3'((m_advances / NP) % 7 + 1);
    if (m_mode == 1) begin
      e_row  = row_in[sel*W +: W];
      e_addr = row_address_in[sel*4 +: 4];
      e_nrst = NP'(1) << sel;
      e_busy = 1'b0;
    end else begin
      e_row  = '0;
      e_addr = 4'((m_edges - 1) % 16);
      e_nrst = '0;
      e_busy = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    check_eq("row",    64'(row_out),             64'(e_row));
    check_eq("addr",   64'(row_address_out),     64'(e_addr));
    check_eq("colour", 64'(colour_out),          64'(e_colour));
    check_eq("sel",    64'(pattern_sel_out),     64'(e_sel));
    check_eq("nrst",   64'(pattern_n_reset_out), 64'(e_nrst));
    check_eq("busy",   64'(busy_out),            64'(e_busy));
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive_random();
      model_step();
      @(negedge clk_in);
      compare_outputs();
    end
  endtask

  initial begin
    int budget;
    n_reset_in = 1'b0;
    next_in = 1'b0;
    hold_in = 1'b0;
    row_in = '0;
    row_address_in = '0;
    hold_left = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_vals("reset");
    n_reset_in = 1'b1;

    run_cycles(1200);

    budget = 0;
    while (m_mode != 2 && budget < 400) begin
      run_cycles(1);
      budget++;
    end
    check_eq("reach_blank", 64'(m_mode), 64'd2);
    run_cycles(3);
    #3 n_reset_in = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk_in);
    check_reset_vals("reset_held");
    n_reset_in = 1'b1;
    hold_left = 0;
    model_reset();

    run_cycles(3000);
    check_eq("lap_coverage", 64'(m_advances >= 7 * NP + 1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
